cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between the execution-side result producers: ALU reservation station, load/store buffer and branch unit.
- Each producer hands over one result (ROB index plus value) through a valid/ready handshake into a private one-entry holding buffer.
- A round-robin scheduler picks one occupied buffer per cycle and drives it onto a registered CDB broadcast.
- Reservation stations, the load/store buffer and the ROB consume that broadcast to wake operands and mark entries complete.

Parameters:
- NUM_REQ, 3, number of producers sharing the CDB (index 0 = ALU RS, 1 = LSB, 2 = branch unit).
- SRC_W, 2, width of the producer index; must satisfy 2^SRC_W >= NUM_REQ.
- ROB_IDX_W, 4, width of a ROB entry tag.
- DATA_W, 32, result value width.

Ports:
- clk_in, input, 1, clock; all state changes on the rising edge.
- rst_in, input, 1, synchronous active-high reset.
- rdy_in, input, 1, global enable; low freezes all state.
- flush_in, input, 1, misprediction flush; discards all pending and in-flight results.
- req_valid, input, NUM_REQ, per-producer result valid.
- req_rob_idx, input, NUM_REQ*ROB_IDX_W, packed per-producer ROB tags; producer i occupies bits [i*ROB_IDX_W +: ROB_IDX_W].
- req_value, input, NUM_REQ*DATA_W, packed per-producer result values.
- req_ready, output, NUM_REQ, per-producer buffer free and block enabled.
- cdb_valid, output, 1, broadcast valid this cycle.
- cdb_rob_idx, output, ROB_IDX_W, broadcast ROB tag.
- cdb_value, output, DATA_W, broadcast value.
- cdb_src, output, SRC_W, index of the producer being broadcast.

Behaviour:
- Reset (rst_in high at an edge):
  - All buffers empty; cdb_valid=0, cdb_rob_idx=0, cdb_value=0, cdb_src=0; round-robin pointer rr_ptr=0.
  - Reset overrides rdy_in and flush_in.
- req_ready[i] = (buffer i empty) && rdy_in && !flush_in.
  - Combinational from registered state only; never depends on req_valid.
- Accept: at an edge where req_valid[i] && req_ready[i], buffer i captures the tag and value and becomes occupied.
- Grant selection (combinational, same cycle):
  - Search occupied buffers starting at rr_ptr, ascending with wrap from NUM_REQ-1 to 0; first occupied index wins.
- At each edge with rdy_in=1 and flush_in=0:
  - If a winner w exists: cdb_valid<=1, cdb_rob_idx/cdb_value<=buffer w contents, cdb_src<=w, buffer w cleared, rr_ptr<=(w+1) mod NUM_REQ.
  - If no winner: cdb_valid<=0; data outputs hold their last values; rr_ptr unchanged.
- Latency:
  - Accepted at edge k, at the latest when no other buffer is occupied: cdb_valid high in the cycle following edge k+1.
  - That producer's req_ready returns high in the same cycle cdb_valid is high. A back-to-back single producer therefore sustains one result every 2 cycles.
- Fairness: an occupied buffer is granted within NUM_REQ grant cycles; no producer starves.
- Simultaneous events:
  - A buffer being granted cannot accept at the same edge, because its req_ready was 0.
  - A freed buffer may accept at the next edge.
  - Other buffers may accept while one is being granted.
- cdb_valid is a one-cycle pulse per grant. Consecutive grants from different producers produce consecutive high cycles.
- flush_in=1 at an edge (rdy_in=1):
  - All buffers emptied, cdb_valid<=0, no accepts, rr_ptr unchanged.
- rdy_in=0: no accepts, no grants, all registers hold, including cdb_valid. Consumers ignore the CDB while rdy_in is low.
- Tag value 0 is a legal ROB index; validity is carried only by cdb_valid.
- Data outputs are don't-care when cdb_valid=0 and must not be relied on.

Decomposition:
- Shared package cpu_defs:
  - ROB_IDX_W, DATA_W.
  - CDB source encodings: SRC_ALU=0, SRC_LSB=1, SRC_BR=2.
  - The CDB record fields (valid, rob_idx, value, src), reused by RS, LSB and ROB.
- One sub-module, rr_pick: a parameterised combinational round-robin picker.
  - Inputs: request mask, start pointer.
  - Outputs: grant_valid, grant_idx.
  - Reusable later for RS issue selection.

Test Plan:
- Reset: hold rst_in 2 cycles with req_valid=3'b111 -> cdb_valid=0, req_ready=3'b000 during reset, req_ready=3'b111 the cycle after release, no accepts during reset.
- Single producer: ALU offers tag 4, value 0x0000_00AA at edge k -> cdb_valid=1, cdb_rob_idx=4, cdb_value=0xAA, cdb_src=0 after edge k+1; req_ready[0] high again that cycle.
- Contention: all three accept simultaneously (tags 1, 2, 3) with rr_ptr=0 -> broadcasts src 0, 1, 2 on three consecutive cycles; rr_ptr ends at 0. Repeat with rr_ptr=2 -> order 2, 0, 1.
- Fairness: LSB and branch unit re-offer every cycle their ready is high for 20 cycles -> grants strictly alternate src 1, 2, 1, 2…; no producer waits more than 2 grants.
- Flush: two buffers occupied, assert flush_in one cycle with req_valid[2]=1 -> next cycle cdb_valid=0, all buffers empty, req_valid[2] not accepted (req_ready was 0), no stale tag broadcast later.
- Stall: buffer 1 holds tag 7; drop rdy_in for 3 cycles -> no change to cdb_valid or buffers, req_ready=0. Raise rdy_in -> tag 7 broadcast after the next edge, exactly once.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: widths, producer encodings and the broadcast record
// consumed by the reservation stations, load/store buffer and ROB.
package cdb_arbiter_pkg;

  localparam int NUM_REQ   = 3;
  localparam int SRC_W     = 2;
  localparam int ROB_IDX_W = 4;
  localparam int DATA_W    = 32;

  typedef enum logic [SRC_W-1:0] {
    SRC_ALU = 2'd0,
    SRC_LSB = 2'd1,
    SRC_BR  = 2'd2
  } cdb_src_e;

  typedef struct packed {
    logic                 valid;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [DATA_W-1:0]    value;
    logic [SRC_W-1:0]     src;
  } cdb_rec_t;

  // Round-robin pointer step; NUM_REQ need not be a power of two.
  function automatic logic [SRC_W-1:0] next_ptr(input logic [SRC_W-1:0] w);
    return (w == SRC_W'(NUM_REQ - 1)) ? '0 : w + SRC_W'(1);
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer handshake plus CDB broadcast bundle; master = producer/consumer side,
// slave = the arbiter.
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*ROB_IDX_W-1:0] req_rob_idx;
  logic [NUM_REQ*DATA_W-1:0]    req_value;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         cdb_valid;
  logic [ROB_IDX_W-1:0]         cdb_rob_idx;
  logic [DATA_W-1:0]            cdb_value;
  logic [SRC_W-1:0]             cdb_src;

  modport master (
    output req_valid, req_rob_idx, req_value,
    input  req_ready, cdb_valid, cdb_rob_idx, cdb_value, cdb_src
  );

  modport slave (
    input  req_valid, req_rob_idx, req_value,
    output req_ready, cdb_valid, cdb_rob_idx, cdb_value, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after start,
// wrapping from N-1 to 0. Also intended for RS issue selection.
module rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  int j;

  // Walk offsets from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    j           = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(start) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one holding buffer per producer, round-robin grant of an occupied
// buffer each cycle onto a registered broadcast.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          flush_in,
  cdb_arbiter_if.slave  bus
);

  logic [NUM_REQ-1:0]   occ;
  logic [ROB_IDX_W-1:0] buf_tag [NUM_REQ];
  logic [DATA_W-1:0]    buf_val [NUM_REQ];
  logic [SRC_W-1:0]     rr_ptr;
  cdb_rec_t             cdb_q;

  logic                 grant_valid;
  logic [SRC_W-1:0]     grant_idx;
  logic [ROB_IDX_W-1:0] win_tag;
  logic [DATA_W-1:0]    win_val;
  logic                 accept_en;

  // Ready is held low through reset so nothing looks acceptable before state is defined.
  assign accept_en     = rdy_in && !flush_in && !rst_in;
  assign bus.req_ready = ~occ & {NUM_REQ{accept_en}};

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (SRC_W)
  ) u_pick (
    .req         (occ),
    .start       (rr_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    win_tag = '0;
    win_val = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == SRC_W'(i)) begin
        win_tag = buf_tag[i];
        win_val = buf_val[i];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      occ    <= '0;
      rr_ptr <= '0;
      cdb_q  <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        buf_tag[i] <= '0;
        buf_val[i] <= '0;
      end
    end else if (rdy_in) begin
      if (flush_in) begin
        occ         <= '0;
        cdb_q.valid <= 1'b0;
      end else begin
        // A granted buffer was occupied, so its ready was low: no accept conflict.
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant_valid && grant_idx == SRC_W'(i)) begin
            occ[i] <= 1'b0;
          end else if (bus.req_valid[i] && bus.req_ready[i]) begin
            occ[i]     <= 1'b1;
            buf_tag[i] <= bus.req_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
            buf_val[i] <= bus.req_value[i*DATA_W +: DATA_W];
          end
        end
        cdb_q.valid <= grant_valid;
        if (grant_valid) begin
          cdb_q.rob_idx <= win_tag;
          cdb_q.value   <= win_val;
          cdb_q.src     <= grant_idx;
          rr_ptr        <= next_ptr(grant_idx);
        end
      end
    end
  end

  assign bus.cdb_valid   = cdb_q.valid;
  assign bus.cdb_rob_idx = cdb_q.rob_idx;
  assign bus.cdb_value   = cdb_q.value;
  assign bus.cdb_src     = cdb_q.src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: expected broadcasts queued at drive time,
// popped and compared by a monitor; table of contention patterns plus corner sequences.
module tb_cdb_arbiter;

  logic clk_in   = 1'b0;
  logic rst_in   = 1'b1;
  logic rdy_in   = 1'b1;
  logic flush_in = 1'b0;
  logic live     = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] value;
    logic [1:0]  src;
  } exp_t;

  typedef struct packed {
    logic [2:0]      mask;
    logic [2:0][3:0] tag;
    logic [1:0]      exp_n;
    logic [2:0][1:0] exp_src;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[7];

  cdb_arbiter_if bus();

  cdb_arbiter dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .flush_in (flush_in),
    .bus      (bus)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] val_of(input int src, input logic [3:0] tag);
    return 32'hC0DE_0000 | (32'(src) << 8) | 32'(tag);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic offer(input int p, input logic [3:0] tag);
    bus.req_valid[p]             = 1'b1;
    bus.req_rob_idx[p*4 +: 4]    = tag;
    bus.req_value[p*32 +: 32]    = val_of(p, tag);
  endtask

  task automatic push_exp(input int p, input logic [3:0] tag);
    exp_t e;
    e.tag   = tag;
    e.value = val_of(p, tag);
    e.src   = 2'(p);
    exp_q.push_back(e);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // A new broadcast appears only after an edge that was enabled and not in reset.
  always @(posedge clk_in) live <= rdy_in && !rst_in;

  always @(negedge clk_in) begin
    if (live && bus.cdb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_bcast: got tag %0h src %0d expected no broadcast",
                 bus.cdb_rob_idx, bus.cdb_src);
      end else begin
        mon_e = exp_q.pop_front();
        chk("bcast_tag",   bus.cdb_rob_idx, mon_e.tag);
        chk("bcast_value", bus.cdb_value,   mon_e.value);
        chk("bcast_src",   bus.cdb_src,     mon_e.src);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] t;
    int s;

    // mask, tags {p2,p1,p0}, grant count, grant order {3rd,2nd,1st}
    vecs[0] = '{3'b111, {4'd3,  4'd2,  4'd1},  2'd3, {2'd2, 2'd1, 2'd0}};
    vecs[1] = '{3'b010, {4'd0,  4'd5,  4'd0},  2'd1, {2'd0, 2'd0, 2'd1}};
    vecs[2] = '{3'b111, {4'd8,  4'd7,  4'd6},  2'd3, {2'd1, 2'd0, 2'd2}};
    vecs[3] = '{3'b101, {4'd10, 4'd0,  4'd9},  2'd2, {2'd0, 2'd0, 2'd2}};
    vecs[4] = '{3'b011, {4'd0,  4'd12, 4'd11}, 2'd2, {2'd0, 2'd0, 2'd1}};
    vecs[5] = '{3'b110, {4'd14, 4'd13, 4'd0},  2'd2, {2'd0, 2'd2, 2'd1}};
    vecs[6] = '{3'b001, {4'd0,  4'd0,  4'd0},  2'd1, {2'd0, 2'd0, 2'd0}};

    bus.req_valid   = 3'b111;
    bus.req_rob_idx = '0;
    bus.req_value   = '0;

    // Reset held two edges with all producers offering.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_in);
      chk("rst_cdb_valid", bus.cdb_valid, 1'b0);
      chk("rst_req_ready", bus.req_ready, 3'b000);
    end
    chk("rst_cdb_tag",   bus.cdb_rob_idx, 4'd0);
    chk("rst_cdb_value", bus.cdb_value,   32'd0);
    chk("rst_cdb_src",   bus.cdb_src,     2'd0);
    rst_in        = 1'b0;
    bus.req_valid = 3'b000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_in);
      chk("post_rst_ready", bus.req_ready, 3'b111);
      chk("post_rst_idle",  bus.cdb_valid, 1'b0);
    end
    step();

    // Single ALU result: broadcast the cycle after the second edge.
    chk("single_ready_before", bus.req_ready, 3'b111);
    offer(0, 4'd4);
    bus.req_value[31:0] = 32'h0000_00AA;
    exp_q.push_back('{tag: 4'd4, value: 32'h0000_00AA, src: 2'd0});
    step();
    bus.req_valid = 3'b000;
    @(negedge clk_in);
    chk("single_ready_busy", bus.req_ready[0], 1'b0);
    chk("single_not_yet",    bus.cdb_valid,    1'b0);
    step();
    @(negedge clk_in);
    chk("single_valid",      bus.cdb_valid,    1'b1);
    chk("single_ready_back", bus.req_ready[0], 1'b1);
    step();
    @(negedge clk_in);
    chk("single_pulse_end",  bus.cdb_valid,    1'b0);
    step();

    // Branch unit alone moves the pointer from 1 back to 0.
    offer(2, 4'd9);
    push_exp(2, 4'd9);
    step();
    bus.req_valid = 3'b000;
    step();
    step();
    drain(10);

    for (int v = 0; v < 7; v++) begin
      chk("vec_ready_idle", bus.req_ready, 3'b111);
      for (int p = 0; p < 3; p++) if (vecs[v].mask[p]) offer(p, vecs[v].tag[p]);
      for (int j = 0; j < int'(vecs[v].exp_n); j++) begin
        s = int'(vecs[v].exp_src[j]);
        push_exp(s, vecs[v].tag[s]);
      end
      step();
      bus.req_valid = 3'b000;
      @(negedge clk_in);
      chk("vec_latency", bus.cdb_valid, 1'b0);
      for (int j = 0; j < int'(vecs[v].exp_n); j++) begin
        step();
        @(negedge clk_in);
        chk("vec_bcast_valid", bus.cdb_valid, 1'b1);
      end
      step();
      @(negedge clk_in);
      chk("vec_idle_after", bus.cdb_valid, 1'b0);
      step();
      chk("vec_drained", exp_q.size(), 0);
    end

    // LSB and branch re-offer whenever ready; pointer starts at 1 so LSB leads.
    t = 4'd1;
    for (int c = 0; c < 20; c++) begin
      for (int p = 1; p < 3; p++) begin
        if (bus.req_ready[p]) begin
          offer(p, t);
          push_exp(p, t);
          t = t + 4'd1;
        end else begin
          bus.req_valid[p] = 1'b0;
        end
      end
      step();
    end
    bus.req_valid = 3'b000;
    drain(20);
    step();
    step();

    // Flush with two buffers occupied and a branch offer during the flush.
    offer(0, 4'd14);
    offer(1, 4'd15);
    step();
    bus.req_valid = 3'b100;
    bus.req_rob_idx[11:8] = 4'd13;
    flush_in = 1'b1;
    @(negedge clk_in);
    chk("flush_ready_low", bus.req_ready, 3'b000);
    step();
    flush_in      = 1'b0;
    bus.req_valid = 3'b000;
    @(negedge clk_in);
    chk("flush_cdb_valid", bus.cdb_valid, 1'b0);
    chk("flush_emptied",   bus.req_ready, 3'b111);
    for (int i = 0; i < 5; i++) step();

    // Stall with LSB holding tag 7, then hold a live broadcast under stall.
    offer(1, 4'd7);
    push_exp(1, 4'd7);
    step();
    bus.req_valid = 3'b000;
    rdy_in        = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      chk("stall_cdb_valid", bus.cdb_valid, 1'b0);
      chk("stall_ready",     bus.req_ready, 3'b000);
      step();
    end
    rdy_in = 1'b1;
    @(negedge clk_in);
    chk("stall_release_ready", bus.req_ready, 3'b101);
    step();
    rdy_in = 1'b0;
    @(negedge clk_in);
    chk("stall_bcast_valid", bus.cdb_valid, 1'b1);
    step();
    @(negedge clk_in);
    chk("stall_hold_valid", bus.cdb_valid,   1'b1);
    chk("stall_hold_tag",   bus.cdb_rob_idx, 4'd7);
    rdy_in = 1'b1;
    step();
    @(negedge clk_in);
    chk("stall_once", bus.cdb_valid, 1'b0);
    for (int i = 0; i < 3; i++) step();

    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
